// File: rtl/alu_mc_pkg.sv
// alu_mc shared types: op codes, FSM states, flag bundle.
// Imported by the ALU core and the multi-cycle wrapper.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_LSL   = 4'b1000,
    ALU_LSR   = 4'b1001,
    ALU_MUL   = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU ops and NZCV flag generation.
// Also used to flag the finished MUL product via PASSB.
import alu_mc_pkg::*;

module alu_comb_core #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic [N-1:0] result,
  output flags_t       flags
);

  localparam int SHW = $clog2(N);

  logic [N:0]     sum;
  logic [N:0]     diff;
  logic [SHW-1:0] shamt;
  logic           c;
  logic           v;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    unique case (1'b1)
      (op == ALU_AND):   result = a & b;
      (op == ALU_OR):    result = a | b;
      (op == ALU_ADD): begin
        result = sum[N-1:0];
        c      = sum[N];
        v      = (a[N-1] == b[N-1]) &
                 (sum[N-1] != a[N-1]);
      end
      (op == ALU_SUB): begin
        result = diff[N-1:0];
        // borrow lands in bit N
        c      = ~diff[N];
        v      = (a[N-1] != b[N-1]) &
                 (diff[N-1] != a[N-1]);
      end
      (op == ALU_PASSB): result = b;
      (op == ALU_LSL):   result = a << shamt;
      (op == ALU_LSR):   result = a >> shamt;
      default:           result = '0;
    endcase
  end

  assign flags.zero     = ~|result;
  assign flags.negative = result[N-1];
  assign flags.carry    = c;
  assign flags.overflow = v;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 1-cycle ops, N-step shift-add MUL,
// valid/ready on both sides with a result hold stage.
import alu_mc_pkg::*;

module alu_mc #(
  parameter int N   = 64,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   alu_control,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow
);

  localparam logic [SHW-1:0] LAST = SHW'(N - 1);

  fsm_state_e     state;
  logic [N-1:0]   acc;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [SHW-1:0] cnt;
  logic [N-1:0]   res_q;
  flags_t         flg_q;

  logic [N-1:0]   acc_next;
  logic [N-1:0]   core_b;
  logic [3:0]     core_op;
  logic [N-1:0]   core_res;
  flags_t         core_flg;
  logic           accept;

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // during MUL the core only flags the product
  assign core_b  = (state == MUL) ? acc_next : b;
  assign core_op = (state == MUL) ? ALU_PASSB
                                  : alu_control;

  alu_comb_core #(.N(N)) u_core (
    .a      (a),
    .b      (core_b),
    .op     (core_op),
    .result (core_res),
    .flags  (core_flg)
  );

  assign in_ready  = (state == IDLE) |
                     ((state == HOLD) & out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      res_q  <= '0;
      flg_q  <= '0;
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (alu_control == ALU_MUL) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              res_q <= core_res;
              flg_q <= core_flg;
              state <= HOLD;
            end
          end else if (state == HOLD && out_ready) begin
            state <= IDLE;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            res_q <= core_res;
            flg_q <= core_flg;
            state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result   = res_q;
  assign zero     = flg_q.zero;
  assign negative = flg_q.negative;
  assign carry    = flg_q.carry;
  assign overflow = flg_q.overflow;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed corner cases plus random
// traffic against a transaction-level reference model.
module tb_alu_mc;

  localparam int N = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic [3:0]    op = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  result;
  logic          zero, negative, carry, overflow;

  int checks = 0;
  int errors = 0;

  alu_mc #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .negative    (negative),
    .carry       (carry),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               name, act, exp);
    end
  endtask

  // {z,n,c,v, result} from plain arithmetic
  function automatic logic [N+3:0] ref_op(
      input logic [3:0] o,
      input logic [N-1:0] x,
      input logic [N-1:0] y);
    logic [N-1:0] r;
    logic c, v;
    logic [N:0] us;
    logic signed [N+1:0] ws;
    r = '0; c = 1'b0; v = 1'b0;
    case (o)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: begin
        us = {1'b0, x} + {1'b0, y};
        r  = us[N-1:0];
        c  = us[N];
        ws = $signed({{2{x[N-1]}}, x}) +
             $signed({{2{y[N-1]}}, y});
        v  = (ws != {{2{ws[N-1]}}, ws[N-1:0]});
      end
      4'b0110: begin
        r  = x - y;
        c  = (x >= y);
        ws = $signed({{2{x[N-1]}}, x}) -
             $signed({{2{y[N-1]}}, y});
        v  = (ws != {{2{ws[N-1]}}, ws[N-1:0]});
      end
      4'b0111: r = y;
      4'b1000: r = x << (y % N);
      4'b1001: r = x >> (y % N);
      4'b1010: r = x * y;
      default: r = '0;
    endcase
    return {(r == '0), r[N-1], c, v, r};
  endfunction

  // reference model: pending output + MUL countdown
  bit           mv = 1'b0;
  int           mbusy = 0;
  logic [N+3:0] mout = '0;
  logic [N+3:0] mpend = '0;

  function automatic bit m_in_ready();
    return (mbusy == 0) && (!mv || out_ready);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mv = 1'b0; mbusy = 0; mout = '0;
    end else if (mbusy > 0) begin
      mbusy--;
      if (mbusy == 0) begin
        mv = 1'b1; mout = mpend;
      end
    end else begin
      bit rdy;
      rdy = m_in_ready();
      if (mv && out_ready) mv = 1'b0;
      if (in_valid && rdy) begin
        if (op == 4'b1010) begin
          mv = 1'b0;
          mbusy = N;
          mpend = ref_op(op, a, b);
        end else begin
          mv = 1'b1;
          mout = ref_op(op, a, b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("m_out_valid", N'(out_valid), N'(mv));
      chk("m_in_ready", N'(in_ready), N'(m_in_ready()));
      if (mv) begin
        chk("m_result", result, mout[N-1:0]);
        chk("m_flags",
            N'({zero, negative, carry, overflow}),
            N'(mout[N+3:N]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o,
                       input logic [N-1:0] x,
                       input logic [N-1:0] y);
    in_valid = 1'b1; op = o; a = x; b = y;
  endtask

  function automatic logic [N-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(N-1){1'b1}}};
      3: return {1'b1, {(N-1){1'b0}}};
      4: return N'($urandom_range(0, 130));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [3:0] ops [10];
    int seen;
    ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7,
            4'h8, 4'h9, 4'hA, 4'h3, 4'hF};

    // reset state
    #12;
    chk("rst_out_valid", N'(out_valid), N'(0));
    chk("rst_result", result, '0);
    chk("rst_flags",
        N'({zero, negative, carry, overflow}), N'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    chk("idle_in_ready", N'(in_ready), N'(1));

    // ADD signed overflow
    drive(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    step();
    in_valid = 1'b0;
    chk("add_valid", N'(out_valid), N'(1));
    chk("add_result", result, 64'h8000_0000_0000_0000);
    chk("add_nzcv",
        N'({negative, zero, carry, overflow}),
        N'(4'b1001));
    step();

    // SUB equal then less, back-to-back
    drive(4'b0110, 64'd5, 64'd5);
    step();
    chk("sub_eq_result", result, '0);
    chk("sub_eq_zc", N'({zero, carry}), N'(2'b11));
    chk("sub_eq_in_ready", N'(in_ready), N'(1));
    drive(4'b0110, 64'd3, 64'd5);
    step();
    in_valid = 1'b0;
    chk("sub_lt_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_lt_nc", N'({negative, carry}), N'(2'b10));
    chk("sub_lt_in_ready", N'(in_ready), N'(1));
    step();

    // MUL latency, with an ignored request mid-run
    drive(4'b1010, 64'd123456789, 64'd1000);
    step();
    in_valid = 1'b0;
    seen = 0;
    for (int i = 1; i <= N; i++) begin
      if (out_valid || in_ready) seen++;
      if (i == 10) drive(4'b0010, 64'd1, 64'd1);
      if (i == 11) in_valid = 1'b0;
      step();
    end
    chk("mul_busy_cycles", N'(seen), N'(0));
    chk("mul_valid", N'(out_valid), N'(1));
    chk("mul_result", result, 64'd123456789000);
    step();

    // backpressure on a shift
    out_ready = 1'b0;
    drive(4'b1000, 64'd1, 64'd67);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", N'(out_valid), N'(1));
      chk("bp_result", result, 64'd8);
      chk("bp_in_ready", N'(in_ready), N'(0));
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", N'(in_ready), N'(1));
    step();
    chk("bp_consumed", N'(out_valid), N'(0));

    // reset in the middle of a MUL
    drive(4'b1010, {$urandom, $urandom}, 64'd77);
    step();
    in_valid = 1'b0;
    repeat (19) step();
    #2;
    reset = 1'b0;
    #1;
    chk("amid_rst_valid", N'(out_valid), N'(0));
    chk("amid_rst_result", result, '0);
    chk("amid_rst_flags",
        N'({zero, negative, carry, overflow}), N'(0));
    step();
    step();
    reset = 1'b1;
    chk("post_rst_ready", N'(in_ready), N'(1));
    seen = 0;
    repeat (N + 8) begin
      step();
      if (out_valid) seen++;
    end
    chk("aborted_mul_silent", N'(seen), N'(0));

    // undefined op code
    drive(4'b1111, 64'hFF, 64'hFF);
    step();
    in_valid = 1'b0;
    chk("undef_valid", N'(out_valid), N'(1));
    chk("undef_result", result, '0);
    chk("undef_flags",
        N'({zero, negative, carry, overflow}),
        N'(4'b1000));
    step();

    // random traffic
    for (int i = 0; i < 500; i++) begin
      logic [3:0] o;
      o = ops[$urandom_range(0, 9)];
      if (o == 4'hA && $urandom_range(0, 7) != 0)
        o = 4'h2;
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = o;
      a  = rand_opnd();
      b  = rand_opnd();
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (N + 4) step();
    chk("drain_idle", N'(out_valid), N'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
